// File: rtl/qspi_pkg.sv
// qspi_pkg: opcodes, dummy-cycle count and FSM state encoding for the QSPI flash responder.
package qspi_pkg;
  localparam logic [7:0] OP_RESET     = 8'hFF;
  localparam logic [7:0] OP_GET_FEAT  = 8'h0F;
  localparam logic [7:0] OP_READ_QUAD = 8'h6B;
  localparam int DUMMY_CYCLES = 32;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_STAT,
    S_DUMMY,
    S_QREAD,
    S_IGNORE
  } state_t;
endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: 2-flop synchronizers for the SPI pins plus rise/fall detect on spi_clk.
module spi_pin_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic [3:0] io_in,
  output logic       sclk_rise,
  output logic       sclk_fall,
  output logic       cs_n_s,
  output logic [3:0] io_s
);
  logic [5:0] s1, s2;
  logic sclk_d;
  // cs_n resets high so nothing is decoded until the host really selects us
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 6'b010000;
      s2 <= 6'b010000;
      sclk_d <= 1'b0;
    end else begin
      s1 <= {spi_clk, spi_cs_n, io_in};
      s2 <= s1;
      sclk_d <= s2[5];
    end
  end
  assign sclk_rise = s2[5] & ~sclk_d;
  assign sclk_fall = ~s2[5] & sclk_d;
  assign cs_n_s = s2[4];
  assign io_s = s2[3:0];
endmodule

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: target-side QSPI NAND model answering Reset, Get Features and Fast Read Quad.
module qspi_flash_responder
  import qspi_pkg::*;
#(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  input  logic              busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              cmd_err
);
  logic rise, fall, cs_n_s;
  logic [3:0] io_s;
  state_t state;
  logic [5:0] cnt;
  logic [7:0] op, status, data_buf;
  logic [7:0] op_next;
  logic [3:0] lo_nib;
  logic hi, rd_d;
  spi_pin_sync u_sync (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .io_in(io_in),
    .sclk_rise(rise), .sclk_fall(fall), .cs_n_s(cs_n_s), .io_s(io_s)
  );
  always_comb op_next = {op[6:0], io_s[0]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      op <= '0;
      status <= '0;
      data_buf <= '0;
      lo_nib <= '0;
      hi <= 1'b1;
      rd_d <= 1'b0;
      io_out <= '0;
      io_oe <= '0;
      mem_rd <= 1'b0;
      mem_addr <= '0;
      cmd_err <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      cmd_err <= 1'b0;
      rd_d <= mem_rd;
      if (rd_d) data_buf <= mem_data;
      // deselect beats any coincident spi_clk edge
      if (cs_n_s) begin
        state <= S_IDLE;
        cnt <= '0;
        hi <= 1'b1;
        io_out <= '0;
        io_oe <= '0;
        mem_addr <= '0;
      end else begin
        case (state)
          S_IDLE: state <= S_CMD;
          S_CMD: if (rise) begin
            op <= op_next;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd7) begin
              cnt <= '0;
              state <= op_next == OP_GET_FEAT ? S_ADDR : op_next == OP_READ_QUAD ? S_DUMMY : S_IGNORE;
              cmd_err <= op_next != OP_RESET && op_next != OP_GET_FEAT && op_next != OP_READ_QUAD;
              if (op_next == OP_READ_QUAD) begin
                mem_rd <= 1'b1;
                mem_addr <= '0;
              end
            end
          end
          S_ADDR: if (rise) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd7) begin
              cnt <= 6'd7;
              status <= {7'b0, busy};
              state <= S_STAT;
            end
          end
          // cnt doubles as the status bit index, MSB first
          S_STAT: if (fall) begin
            io_out <= {2'b00, status[cnt[2:0]], 1'b0};
            io_oe <= 4'b0010;
            cnt <= cnt == 6'd0 ? 6'd7 : cnt - 6'd1;
            if (cnt == 6'd0) status <= {7'b0, busy};
          end
          S_DUMMY: if (rise) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'(DUMMY_CYCLES - 1)) begin
              cnt <= '0;
              hi <= 1'b1;
              state <= S_QREAD;
            end
          end
          // low nibble is parked so the prefetch may overwrite data_buf
          S_QREAD: if (fall) begin
            io_oe <= 4'hF;
            io_out <= hi ? data_buf[7:4] : lo_nib;
            hi <= ~hi;
            if (hi) begin
              lo_nib <= data_buf[3:0];
              mem_rd <= 1'b1;
              mem_addr <= mem_addr + 1'b1;
            end
          end
          S_IGNORE: state <= S_IGNORE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/qspi_flash_responder.md
# qspi_flash_responder

Synthesizable QSPI serial-NAND target that answers the flash controller's command sequence from the target side. It decodes Device Reset (0xFF), Get Features (0x0F) and Fast Read Quad Output (0x6B), and streams bytes from a synchronous-read memory port onto IO[3:0]. It replaces the external flash in FPGA bring-up and in self-checking benches. It oversamples the SPI pins in its own `clk` domain.

## Interface
- `ADDR_W`, default 18: byte-address width of the memory port. Read address wraps modulo 2^ADDR_W.
- `clk` input 1: system clock. Must be at least 8× `spi_clk`.
- `rst_n` input 1: reset, synchronous, active-low.
- `spi_clk` input 1: SPI clock from the host, asynchronous.
- `spi_cs_n` input 1: chip select from the host, active-low, asynchronous.
- `io_in` input 4: IO[3:0] pin inputs. IO0 is DI.
- `io_out` output 4: IO[3:0] pin drive values.
- `io_oe` output 4: per-pin output enable, 1 = drive.
- `busy` input 1: reported as status bit 0 (OIP).
- `mem_rd` output 1: one-cycle read strobe.
- `mem_addr` output ADDR_W: read byte address.
- `mem_data` input 8: read data, valid on the cycle after `mem_rd`.
- `cmd_err` output 1: one-cycle pulse when an unsupported opcode completes.

## Operation
- **Input sync.** `spi_clk`, `spi_cs_n` and `io_in` each pass through a 2-flop synchronizer. Rise and fall are detected on the synchronized `spi_clk` using a third flop.
- **Sampling and driving.**
  - Inputs are sampled on each detected rise.
  - Outputs are updated on each detected fall.
  - All counting happens only while synchronized `cs_n` is 0.
- **State machine.**
  - IDLE: wait for synchronized `cs_n` = 0, then go to CMD.
  - CMD: shift IO0 into the opcode register, MSB first, over 8 rises. On the 8th rise, branch by opcode:
    - 0xFF → IGNORE.
    - 0x0F → ADDR.
    - 0x6B → DUMMY.
    - Any other opcode → IGNORE, and pulse `cmd_err`.
  - ADDR: 8 rises; the feature address is discarded. Then latch status = {7'b0, `busy`} and go to STAT.
  - STAT: on each fall, drive the next status bit on IO1 (MSB first) with `io_oe` = 4'b0010. After bit 0 the status byte repeats, re-latching `busy` each time (the host polls by holding CS low).
  - DUMMY: 32 rises, IO ignored. On entry, assert `mem_rd` with `mem_addr` = 0. Then go to QREAD.
  - QREAD: `io_oe` = 4'b1111. Each fall drives the next nibble, high nibble first. On the high-nibble fall, assert `mem_rd` for address+1 to prefetch the following byte. The address increments modulo 2^ADDR_W.
  - IGNORE: hold until `cs_n` goes high.
- **CS deassert.** Synchronized `cs_n` = 1 in any state:
  - next cycle: state = IDLE, `io_oe` = 0, counters and address cleared;
  - every transaction restarts reading at address 0.
- **Simultaneous events.** If a fall and CS deassert coincide, CS wins and no new value is driven.
- **Reset.** All state returns to IDLE on the next `clk` edge, including mid-transaction.
  - Reset values: `io_out` = 0, `io_oe` = 0, `mem_rd` = 0, `mem_addr` = 0, `cmd_err` = 0.

## Timing
- Pin-to-internal latency is 3 `clk` cycles: 2 sync flops plus edge detect.
- Output change follows an `spi_clk` fall by 3–4 `clk` cycles. At 8× ratio this settles before the next host rise.
- First status bit is driven on the fall after the 8th address rise.
- First quad nibble is driven on the fall after the 32nd dummy rise. This is 40 SPI clocks after CS low.
- Prefetch margin: `mem_data` is captured 1 cycle after `mem_rd` and needed ≥1 SPI half-period later.
- `cmd_err` pulses on the cycle the 8th opcode bit is processed.

## Structure
- Shared package `qspi_pkg`:
  - opcodes OP_RESET = 8'hFF, OP_GET_FEAT = 8'h0F, OP_READ_QUAD = 8'h6B;
  - DUMMY_CYCLES = 32;
  - state enum encoding.
- One sub-module: `spi_pin_sync`. It holds the 2-flop synchronizer vector plus rise/fall detect for `spi_clk`. Everything else stays in one FSM module.

## Test plan
- Unsupported opcode: CS low, send 0x9F → `cmd_err` one pulse, `io_oe` stays 0 until CS high, then IDLE.
- Get Features with `busy` = 1: send 0x0F, 0xC0, clock 16 more → IO1 reads 0x01 twice. Drop `busy` during the second byte → the third byte reads 0x00.
- Quad read: memory holds [0]=0xA5, [1]=0x3C, [2]=0x7E. Send 0x6B plus 32 dummies, then 6 clocks → host samples A,5,3,C,7,E. `mem_addr` sequence is 0,1,2,3; `io_oe` = 4'hF.
- CS mid-read: deassert after 3 nibbles → `io_oe` = 0 within 4 `clk` cycles. A new 0x6B transaction returns nibble A first.
- Wrap: ADDR_W = 4; read 17 bytes → the 17th equals byte 0 and `mem_addr` wraps to 0.
- Reset mid-STAT: assert `rst_n` = 0 for one cycle → all outputs at reset values next edge. The following 0x0F transaction behaves normally.
